// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package period_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Default counter width and abort threshold
    localparam int          DEFAULT_COUNTER_SIZE = 16;
    localparam logic [15:0] DEFAULT_TIMEOUT_MAX  = 16'd50000;

    // True for the states in which a measurement is in flight
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_ARM) || (s == ST_MEASURE);
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// Request/result bundle between a period meter and its user.
// Latency: n/a (wiring only).
// Backpressure: none; start is a one-cycle request that is ignored while busy.
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNTER_SIZE
) ();

    logic             signal_in;  // asynchronous waveform to be measured
    logic             start;      // one-cycle measurement request
    logic             busy;       // measurement in progress
    logic             done;       // one-cycle result strobe
    logic             timeout;    // last measurement aborted
    logic [WIDTH-1:0] period;     // last measured period in clock cycles

    // User side: drives the waveform and the request, observes results
    modport master (
        output signal_in,
        output start,
        input  busy,
        input  done,
        input  timeout,
        input  period
    );

    // Meter side
    modport slave (
        input  signal_in,
        input  start,
        output busy,
        output done,
        output timeout,
        output period
    );

endinterface

// File: rtl/period_meter_signal_synchronizer.sv
// Two-flop synchronizer plus history flop producing a rising-edge pulse.
// Latency: rise_pulse is high in the 3rd cycle after async_in is first sampled high.
// Backpressure: none; free-running.
module signal_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_q;   // first stage, may go metastable
    logic sync_q;   // second stage, safe to use
    logic hist_q;   // previous synchronized value for edge detection

    // Synchronizer chain and history flop, all cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_out   = sync_q;
    // Rising edge: synchronized value now high, was low one cycle ago
    assign rise_pulse = sync_q & ~hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the clock-cycle distance between two consecutive rising edges of signal_in.
// Latency: done one cycle after the second detected edge (or after the counter reaches TIMEOUT_MAX).
// Backpressure: start is accepted only in IDLE; requests while busy or in DONE are dropped.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int                      COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
    parameter logic [COUNTER_SIZE-1:0] TIMEOUT_MAX  = COUNTER_SIZE'(DEFAULT_TIMEOUT_MAX)
) (
    input  logic           clock,
    input  logic           reset,
    period_meter_if.slave  bus
);

    // The interface WIDTH must equal COUNTER_SIZE at the instantiation site.

    logic sync_level_unused;   // level output of the synchronizer, not needed here
    logic sig_rise;            // one-cycle rising-edge strobe, already synchronized

    signal_synchronizer u_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (bus.signal_in),
        .sync_out   (sync_level_unused),
        .rise_pulse (sig_rise)
    );

    state_t                  state_q,   state_d;
    logic [COUNTER_SIZE-1:0] counter_q, counter_d;
    logic [COUNTER_SIZE-1:0] period_q,  period_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;

    logic [COUNTER_SIZE-1:0] counter_inc;
    logic                    at_limit;

    // Counting stops at TIMEOUT_MAX, so the increment can never wrap
    assign counter_inc = counter_q + COUNTER_SIZE'(1);
    assign at_limit    = (counter_q == TIMEOUT_MAX);

    // Next-state, counter and result logic; an edge always beats the timeout
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        period_d  = period_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_ARM;
                    counter_d = '0;
                    timeout_d = 1'b0;
                end
            end

            ST_ARM: begin
                if (sig_rise) begin
                    // First edge: the cycle after it is cycle 1 of the period
                    state_d   = ST_MEASURE;
                    counter_d = COUNTER_SIZE'(1);
                end else if (at_limit) begin
                    state_d   = ST_DONE;
                    period_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    counter_d = counter_inc;
                end
            end

            ST_MEASURE: begin
                if (sig_rise) begin
                    state_d   = ST_DONE;
                    period_d  = counter_q;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    state_d   = ST_DONE;
                    period_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    counter_d = counter_inc;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so outputs come straight from flops
    always_comb begin
        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and output registers; reset aborts any measurement silently
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.period  = period_q;

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter: COUNTER_SIZE, 16, width of the period counter and period output.
REQ-002 Parameter: TIMEOUT_MAX, 16'd50000, cycle count at which a measurement aborts; SHALL be at least 2 and representable in COUNTER_SIZE bits.
REQ-003 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: signal_in  input  1  asynchronous slow clock or pulse train to be measured, e.g. a divided clock.
REQ-006 Port: start  input  1  one-cycle request to begin a measurement.
REQ-007 Port: busy  output  1  high from acceptance of start until done.
REQ-008 Port: done  output  1  one-cycle pulse when a result is available.
REQ-009 Port: timeout  output  1  high when the last measurement aborted; valid from done until the next accepted start.
REQ-010 Port: period  output  COUNTER_SIZE  clock cycles between two consecutive rising edges of signal_in; valid from done until the next accepted start.

Function
REQ-011 signal_in SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is sync=1 and history=0, giving a fixed 3-cycle detection latency.
REQ-012 FSM states SHALL be IDLE, ARM, MEASURE, DONE.
REQ-013 IDLE: start=1 -> ARM, counter cleared to 0, timeout cleared, busy=1 on the next cycle; start=0 -> stay.
REQ-014 ARM: rising edge -> MEASURE with counter=1; otherwise counter increments.
REQ-015 MEASURE: rising edge -> DONE with period=counter; otherwise counter increments.
REQ-016 In ARM or MEASURE, counter==TIMEOUT_MAX with no edge that cycle -> DONE with period=0 and timeout=1.
REQ-017 In MEASURE, an edge in the same cycle as counter==TIMEOUT_MAX SHALL win: period=TIMEOUT_MAX, timeout=0.
REQ-018 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-019 start SHALL be ignored in ARM, MEASURE and DONE; it is not queued.
REQ-020 A signal_in with period P cycles, whether symmetric or not, SHALL yield period=P for 2 <= P <= TIMEOUT_MAX.
REQ-021 Counter increments SHALL never wrap, because timeout terminates counting at TIMEOUT_MAX.
REQ-022 period and timeout SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-023 Reset SHALL force IDLE with counter=0, busy=0, done=0, timeout=0, period=0, and all synchronizer and history flops = 0.
REQ-024 Reset asserted mid-measurement SHALL abort it without asserting done; the next start after release SHALL measure normally.
REQ-025 Reset SHALL take priority over start and edge events in the same cycle.

Structure
REQ-026 FSM state encoding constants and the default TIMEOUT_MAX SHALL live in a shared package, period_meter_pkg.
REQ-027 The synchronizer and edge detector SHALL be one sub-module, signal_synchronizer, with ports clock, reset, async_in, sync_out and rise_pulse.
REQ-028 All remaining logic (FSM, counter and output registers) SHALL be in period_meter; no combinational path from inputs to outputs.

Verification
REQ-029 TIMEOUT_MAX=1000; signal_in a 50/50 square wave of period 100 cycles; start pulse -> done once, period=100, timeout=0.
REQ-030 signal_in toggling every cycle (P=2); start -> period=2, timeout=0.
REQ-031 signal_in held 0 with TIMEOUT_MAX=1000; start -> done exactly 1000 cycles after ARM entry, period=0, timeout=1.
REQ-032 Second rising edge aligned with counter==TIMEOUT_MAX=64 -> period=64, timeout=0; aligned one cycle later -> period=0, timeout=1.
REQ-033 Extra start pulses during MEASURE -> ignored: exactly one done, period unchanged (100).
REQ-034 Reset pulsed in MEASURE -> all outputs 0, no done; a new start then yields period=100.
